sub_operand_sweeper: RTL and testbench
======================================

# sub_operand_sweeper

Sequential operand generator and result checker placed directly upstream of the five-bit subtractor. After a start pulse it drives every ordered pair (A, B) with MIN_VAL ≤ B ≤ A ≤ MAX_VAL onto the subtractor inputs, one pair per handshake. It compares the returned difference against the expected value and reports the pair count and the mismatch count when the sweep ends.

## Interface
- WIDTH, 5, operand width; the difference is WIDTH+1 bits
- MIN_VAL, 1, first operand value; 0 ≤ MIN_VAL ≤ MAX_VAL
- MAX_VAL, 15, last operand value; MAX_VAL ≤ 2^WIDTH−1
- CNT_W, 8, width of pair_count and err_count
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begins a sweep; sampled only in IDLE
- ready  in  1  consumer accepts the current pair this cycle
- d_in  in  WIDTH+1  subtractor difference for the current a_out/b_out, valid in the same cycle
- a_out  out  WIDTH  minuend
- b_out  out  WIDTH  subtrahend
- valid  out  1  a_out/b_out hold a pair to be consumed
- busy  out  1  sweep in progress (RUN state)
- done  out  1  one-cycle pulse when the sweep completes
- pair_count  out  CNT_W  pairs accepted in the current or last sweep
- err_count  out  CNT_W  mismatches in the current or last sweep

## Operation
- States:
  - IDLE: valid=0, busy=0. If start=1, go to RUN, load a_out=b_out=MIN_VAL, and clear pair_count and err_count.
  - RUN: valid=1, busy=1. A handshake occurs when valid&&ready.
    - On each handshake, pair_count increments by 1.
    - If d_in ≠ {1'b0, a_out} − {1'b0, b_out} (computed at WIDTH+1 bits), err_count increments by 1.
    - Step rule when b_out < a_out: b_out += 1.
    - Step rule when b_out == a_out and a_out < MAX_VAL: a_out += 1 and b_out = MIN_VAL.
    - When b_out == a_out == MAX_VAL, go to DONE.
    - Without a handshake, all outputs hold.
  - DONE: done=1, valid=0, busy=0 for exactly one cycle, then return to IDLE unconditionally.
- Counters saturate at 2^CNT_W−1 and never wrap.
- In IDLE, pair_count, err_count, a_out and b_out keep their last values until the next start.
- start is ignored in RUN and in DONE.
- A start asserted during the DONE cycle is lost.
- With the default parameters a full sweep yields N(N+1)/2 pairs, where N = MAX_VAL−MIN_VAL+1 = 15, giving 120 pairs.
- Because b_out ≤ a_out always holds, the expected difference is non-negative and its MSB (borrow) is 0.

## Timing
- Reset values: state=IDLE, a_out=0, b_out=0, valid=0, busy=0, done=0, pair_count=0, err_count=0.
- Reset has priority over every other input, including in the middle of a sweep.
  - After reset the block is in IDLE with no done pulse.
  - Partial counts are cleared.
- Start latency: start=1 in IDLE at edge k gives valid=1 with a_out=b_out=MIN_VAL after edge k, i.e. in cycle k+1.
- Each handshake at edge n presents the next pair in cycle n+1.
  - With ready held high, throughput is one pair per cycle.
- d_in is sampled only at handshake edges; its value in other cycles is ignored.
- With ready held high from cycle k+1, the default sweep has RUN lasting 120 cycles, done in cycle k+121, and IDLE in cycle k+122.
- ready low stalls the sweep: a_out/b_out and valid stay stable until accepted.
  - A consumer may hold ready low indefinitely.
- The final-pair handshake updates pair_count/err_count on the same edge that enters DONE, so both are final while done=1.
- MIN_VAL == MAX_VAL gives a single-pair sweep: one handshake, then DONE.

## Test plan
- Defaults, ready=1, correct subtractor model on d_in, start pulse → exactly 120 handshakes.
  - First pair (1,1), second (2,1), last (15,15).
  - done is high for 1 cycle with pair_count=120, err_count=0.
- Random ready stalls (≈50% duty) → the same 120-pair sequence in the same order.
  - a_out/b_out never change while valid=1 and ready=0.
  - The totals match the unstalled run.
- Fault injection: d_in forced to expected+1 for pairs (7,3) and (15,15) → err_count=2, pair_count=120.
- rst asserted after 40 handshakes → the following cycle shows valid=0, busy=0, pair_count=0, err_count=0, a_out=b_out=0, and no done.
  - A new start then reproduces the full 120-pair sweep.
- start held high across RUN and DONE → a single sweep with a single done pulse.
  - A fresh start in IDLE begins a second sweep with the counters restarted from 0.
- Parameters MIN_VAL=MAX_VAL=31 → one handshake with pair (31,31) and expected d_in=0, then done with pair_count=1.

Source files
------------

// File: rtl/sub_operand_sweeper.sv
// sub_operand_sweeper
//   Operand generator and result checker for a WIDTH-bit subtractor. After a
//   start pulse it walks every ordered pair (A, B) with
//   MIN_VAL <= B <= A <= MAX_VAL, one pair per valid/ready handshake. Each
//   returned difference is checked against {0,A}-{0,B}. The block keeps
//   saturating counts of accepted pairs and mismatches.
//
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   start       : begin a sweep (honoured only in IDLE)
//   ready       : consumer accepts the current pair this cycle
//   d_in        : subtractor difference for the current a_out/b_out
//   a_out/b_out : minuend / subtrahend
//   valid       : a_out/b_out carry a pair to be consumed
//   busy        : sweep in progress
//   done        : one-cycle pulse at sweep completion
//   pair_count  : pairs accepted in the current or last sweep
//   err_count   : mismatches in the current or last sweep
module sub_operand_sweeper #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 1,
  parameter int unsigned MAX_VAL = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
  input  logic [WIDTH:0]   d_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0] exp_diff;
  logic           last_pair;
  logic           handshake;

  // b_out never exceeds a_out, so the borrow bit of the expected value is 0.
  assign exp_diff  = {1'b0, a_out} - {1'b0, b_out};
  assign last_pair = (a_out == MAX_V) && (b_out == MAX_V);
  assign handshake = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready && last_pair) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand stepping and counters. Outputs hold whenever no handshake occurs;
  // the final handshake updates the counters on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out      <= '0;
      b_out      <= '0;
      pair_count <= '0;
      err_count  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a_out      <= MIN_V;
        b_out      <= MIN_V;
        pair_count <= '0;
        err_count  <= '0;
      end
    end else if (handshake) begin
      if (pair_count != '1)
        pair_count <= pair_count + CNT_W'(1);
      if ((d_in != exp_diff) && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
      if (b_out < a_out) begin
        b_out <= b_out + WIDTH'(1);
      end else if (a_out < MAX_V) begin
        a_out <= a_out + WIDTH'(1);
        b_out <= MIN_V;
      end
    end
  end

endmodule

// File: tb/tb_sub_operand_sweeper.sv
module tb_sub_operand_sweeper;

  localparam int unsigned MINV = 1;
  localparam int unsigned MAXV = 15;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic [5:0] d_in;
  logic [4:0] a_out, b_out;
  logic       valid, busy, done;
  logic [7:0] pair_count, err_count;

  // Single-pair instance (MIN_VAL == MAX_VAL == 31)
  logic       start1, ready1;
  logic [5:0] d_in1;
  logic [4:0] a_out1, b_out1;
  logic       valid1, busy1, done1;
  logic [7:0] pair_count1, err_count1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  sub_operand_sweeper #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .d_in(d_in),
    .a_out(a_out), .b_out(b_out), .valid(valid), .busy(busy), .done(done),
    .pair_count(pair_count), .err_count(err_count)
  );

  sub_operand_sweeper #(.WIDTH(5), .MIN_VAL(31), .MAX_VAL(31), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready1), .d_in(d_in1),
    .a_out(a_out1), .b_out(b_out1), .valid(valid1), .busy(busy1), .done(done1),
    .pair_count(pair_count1), .err_count(err_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep on the default instance. abort_after > 0 applies reset after
  // that many handshakes instead of completing the sweep.
  task automatic sweep(input bit rand_ready, input bit inject, input int abort_after,
                       input bit hold_start, input int exp_errs);
    int unsigned ea, eb;
    int          hs, cyc;
    bit          seen_done, hs_now;
    ea = MINV; eb = MINV; hs = 0; cyc = 0; seen_done = 0;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    cyc = 1;
    check("start_valid", valid, 1);
    check("start_busy", busy, 1);
    check("start_pc_clear", pair_count, 0);
    check("start_ec_clear", err_count, 0);
    while (!seen_done && cyc < 2000) begin
      if (valid) begin
        check("pair_a", a_out, ea);
        check("pair_b", b_out, eb);
      end
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready) begin
        d_in = {1'b0, a_out} - {1'b0, b_out};
        if (inject && ((a_out == 5'd7 && b_out == 5'd3) || (a_out == 5'd15 && b_out == 5'd15)))
          d_in = d_in + 6'd1;
      end else begin
        d_in = 6'($urandom); // ignored while not handshaking
      end
      hs_now = valid && ready;
      tick();
      cyc++;
      if (hs_now) begin
        hs++;
        if (eb < ea) eb++;
        else if (ea < MAXV) begin ea++; eb = MINV; end
        if (abort_after > 0 && hs == abort_after) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check("rst_valid", valid, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_pc", pair_count, 0);
          check("rst_ec", err_count, 0);
          check("rst_ab", {a_out, b_out}, 0);
          tick();
          check("rst_idle_done", done, 0);
          check("rst_idle_valid", valid, 0);
          return;
        end
      end
      if (done) begin
        seen_done = 1;
        check("done_pairs_seen", hs, 120);
        check("done_pc", pair_count, 120);
        check("done_ec", err_count, exp_errs);
        check("done_valid", valid, 0);
        check("done_busy", busy, 0);
        if (!rand_ready) check("done_latency", cyc, 121);
      end
    end
    if (!seen_done) begin
      check("done_timeout", 0, 1);
      return;
    end
    ready = 1'b0;
    tick(); // edge leaving DONE; a held start here is lost
    start = 1'b0;
    check("post_done_pulse", done, 0);
    check("post_idle_valid", valid, 0);
    check("post_idle_busy", busy, 0);
    tick();
    check("idle_no_restart", valid, 0);
    check("idle_hold_pc", pair_count, 120);
    check("idle_hold_ec", err_count, exp_errs);
    check("idle_hold_ab", {a_out, b_out}, {5'd15, 5'd15});
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; ready = 1'b1; d_in = '0;
    start1 = 1'b0; ready1 = 1'b0; d_in1 = '0;
    tick(); tick();
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pc", pair_count, 0);
    check("reset_ec", err_count, 0);
    check("reset_ab", {a_out, b_out}, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_after_reset", valid, 0);

    sweep(1'b0, 1'b0, 0, 1'b0, 0);   // ready held high
    sweep(1'b1, 1'b0, 0, 1'b0, 0);   // random stalls
    sweep(1'b0, 1'b1, 0, 1'b0, 2);   // two injected faults
    sweep(1'b1, 1'b1, 0, 1'b0, 2);   // faults under stalls
    sweep(1'b0, 1'b0, 40, 1'b0, 0);  // reset mid-sweep
    sweep(1'b0, 1'b0, 0, 1'b0, 0);   // full sweep after reset
    sweep(1'b0, 1'b1, 0, 1'b1, 2);   // start held across RUN and DONE
    sweep(1'b0, 1'b0, 0, 1'b0, 0);   // fresh start restarts counters

    // Single-pair sweep: pair (31,31), expected difference 0
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("single_valid", valid1, 1);
    check("single_pair", {a_out1, b_out1}, {5'd31, 5'd31});
    ready1 = 1'b1; d_in1 = 6'd0;
    tick();
    ready1 = 1'b0;
    check("single_done", done1, 1);
    check("single_valid_off", valid1, 0);
    check("single_pc", pair_count1, 1);
    check("single_ec", err_count1, 0);
    tick();
    check("single_done_pulse", done1, 0);
    check("single_idle_busy", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
